// File: rtl/des_pkg.sv
// DES constant tables, decrypt key schedule, FSM state type and permutation helpers.
// Bit 63 of a 64-bit word is DES bit 1; table entries are 1-based DES bit numbers.
package des_pkg;

    typedef enum logic [1:0] {IDLE, ROUND, DONE} state_e;

    localparam int IP_T [64] = '{
        58, 50, 42, 34, 26, 18, 10, 2,  60, 52, 44, 36, 28, 20, 12, 4,
        62, 54, 46, 38, 30, 22, 14, 6,  64, 56, 48, 40, 32, 24, 16, 8,
        57, 49, 41, 33, 25, 17,  9, 1,  59, 51, 43, 35, 27, 19, 11, 3,
        61, 53, 45, 37, 29, 21, 13, 5,  63, 55, 47, 39, 31, 23, 15, 7};

    localparam int FP_T [64] = '{
        40, 8, 48, 16, 56, 24, 64, 32,  39, 7, 47, 15, 55, 23, 63, 31,
        38, 6, 46, 14, 54, 22, 62, 30,  37, 5, 45, 13, 53, 21, 61, 29,
        36, 4, 44, 12, 52, 20, 60, 28,  35, 3, 43, 11, 51, 19, 59, 27,
        34, 2, 42, 10, 50, 18, 58, 26,  33, 1, 41,  9, 49, 17, 57, 25};

    localparam int E_T [48] = '{
        32,  1,  2,  3,  4,  5,   4,  5,  6,  7,  8,  9,
         8,  9, 10, 11, 12, 13,  12, 13, 14, 15, 16, 17,
        16, 17, 18, 19, 20, 21,  20, 21, 22, 23, 24, 25,
        24, 25, 26, 27, 28, 29,  28, 29, 30, 31, 32,  1};

    localparam int P_T [32] = '{
        16,  7, 20, 21, 29, 12, 28, 17,   1, 15, 23, 26,  5, 18, 31, 10,
         2,  8, 24, 14, 32, 27,  3,  9,  19, 13, 30,  6, 22, 11,  4, 25};

    localparam int PC1_T [56] = '{
        57, 49, 41, 33, 25, 17,  9,   1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27,  19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,   7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29,  21, 13,  5, 28, 20, 12,  4};

    localparam int PC2_T [48] = '{
        14, 17, 11, 24,  1,  5,   3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8,  16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55,  30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53,  46, 42, 50, 36, 29, 32};

    // Right-rotation per decrypt round: the encrypt left-shift schedule replayed backwards.
    localparam logic [1:0] SCHED [16] = '{
        2'd0, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
        2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1};

    // Each S-box: 64 nibbles, entry (row*16+col) starting at the MSB nibble.
    localparam logic [255:0] SBOX [8] = '{
        256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
        256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
        256'hA09E63F51DC7B428_D70934A6285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
        256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
        256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
        256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
        256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
        256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B};

    function automatic logic [63:0] ip(input logic [63:0] x);
        logic [63:0] y;
        y = '0;
        for (int i = 0; i < 64; i++) y[63-i] = x[64-IP_T[i]];
        return y;
    endfunction

    function automatic logic [63:0] fp(input logic [63:0] x);
        logic [63:0] y;
        y = '0;
        for (int i = 0; i < 64; i++) y[63-i] = x[64-FP_T[i]];
        return y;
    endfunction

    function automatic logic [47:0] e_exp(input logic [31:0] x);
        logic [47:0] y;
        y = '0;
        for (int i = 0; i < 48; i++) y[47-i] = x[32-E_T[i]];
        return y;
    endfunction

    function automatic logic [31:0] p_perm(input logic [31:0] x);
        logic [31:0] y;
        y = '0;
        for (int i = 0; i < 32; i++) y[31-i] = x[32-P_T[i]];
        return y;
    endfunction

    function automatic logic [55:0] pc1(input logic [63:0] x);
        logic [55:0] y;
        y = '0;
        for (int i = 0; i < 56; i++) y[55-i] = x[64-PC1_T[i]];
        return y;
    endfunction

    function automatic logic [47:0] pc2(input logic [55:0] x);
        logic [47:0] y;
        y = '0;
        for (int i = 0; i < 48; i++) y[47-i] = x[56-PC2_T[i]];
        return y;
    endfunction

    // Row is b1,b6 and column b2..b5, with b1 the MSB of the 6-bit group.
    function automatic logic [3:0] sbox(input int n, input logic [5:0] b);
        logic [5:0] idx;
        idx = {b[5], b[0], b[4:1]};
        return SBOX[n][255 - 4*int'(idx) -: 4];
    endfunction

    function automatic logic [27:0] rotr28(input logic [27:0] x, input logic [1:0] n);
        case (n)
            2'd0:    return x;
            2'd1:    return {x[0], x[27:1]};
            default: return {x[1:0], x[27:2]};
        endcase
    endfunction

endpackage

// File: rtl/des_f_func.sv
// DES round function f(R,K): E-expansion, key mix, S1..S8, P permutation.
// Purely combinational, zero latency, no handshake.
module des_f_func
    import des_pkg::*;
(
    input  logic [31:0] r_i,
    input  logic [47:0] k_i,
    output logic [31:0] f_o
);

    logic [47:0] mix;
    logic [31:0] sub;

    always_comb begin
        mix = e_exp(r_i) ^ k_i;
        sub = '0;
        for (int n = 0; n < 8; n++) sub[31-4*n -: 4] = sbox(n, mix[47-6*n -: 6]);
        f_o = p_perm(sub);
    end

endmodule

// File: rtl/des_decrypt_iter.sv
// Iterative DES decryption, one Feistel round per cycle; out_valid 16 cycles after accept.
// in_ready only in IDLE; result held in DONE until out_ready, then back to IDLE.
module des_decrypt_iter
    import des_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] ct_in,
    input  logic [63:0] key_in,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] pt_out,
    output logic        busy
);

    state_e      state_q, state_d;
    logic [4:0]  rnd_q, rnd_d;
    logic [31:0] l_q, l_d, r_q, r_d;
    logic [27:0] c_q, c_d, d_q, d_d;
    logic [63:0] pt_q, pt_d;
    logic        ov_q, ov_d;

    logic [1:0]  shift;
    logic [27:0] c_rot, d_rot;
    logic [47:0] subkey;
    logic [31:0] f_out;

    // rnd_q runs 1..16 in ROUND; the table index is rnd-1.
    assign shift  = SCHED[4'(rnd_q - 5'd1)];
    assign c_rot  = rotr28(c_q, shift);
    assign d_rot  = rotr28(d_q, shift);
    assign subkey = pc2({c_rot, d_rot});

    des_f_func u_f (
        .r_i (r_q),
        .k_i (subkey),
        .f_o (f_out)
    );

    always_comb begin
        state_d = state_q;
        rnd_d   = rnd_q;
        l_d     = l_q;
        r_d     = r_q;
        c_d     = c_q;
        d_d     = d_q;
        pt_d    = pt_q;
        ov_d    = ov_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    {l_d, r_d} = ip(ct_in);
                    {c_d, d_d} = pc1(key_in);
                    rnd_d      = 5'd1;
                    state_d    = ROUND;
                end
            end
            ROUND: begin
                c_d = c_rot;
                d_d = d_rot;
                l_d = r_q;
                r_d = l_q ^ f_out;
                if (rnd_q == 5'd16) begin
                    // Final swap: preoutput is {R16, L16}.
                    pt_d    = fp({l_q ^ f_out, r_q});
                    ov_d    = 1'b1;
                    rnd_d   = 5'd0;
                    state_d = DONE;
                end else begin
                    rnd_d = rnd_q + 5'd1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    ov_d    = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            rnd_q   <= '0;
            l_q     <= '0;
            r_q     <= '0;
            c_q     <= '0;
            d_q     <= '0;
            pt_q    <= '0;
            ov_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            rnd_q   <= rnd_d;
            l_q     <= l_d;
            r_q     <= r_d;
            c_q     <= c_d;
            d_q     <= d_d;
            pt_q    <= pt_d;
            ov_q    <= ov_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign out_valid = ov_q;
    assign pt_out    = pt_q;

endmodule
